solver_dispatch: RTL and testbench

- Upstream feeder for the per-pixel solver control block.
- Accepts pixel jobs from a host word stream: header, then real limbs of c, then imaginary limbs of c.
- Loads each job into the solver (num_limbs, iteration limit, c limbs), pulses start, waits for completion, and returns the tagged iteration count on a result stream.
- Holds one result in a register, so the next job can load while the previous result waits for the consumer.

---
 rtl/solver_dispatch_if.sv | 47 ++++
 rtl/solver_dispatch.sv | 162 ++++++++++++++++
 tb/tb_solver_dispatch.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/solver_dispatch_if.sv
// Host word stream, solver load/control bus and result stream of the solver dispatcher.
interface solver_dispatch_if #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int DATA_BITS       = 32,
    parameter int TAG_BITS        = 8
) ();
    // Host word stream
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_BITS-1:0]       in_data;
    // Solver load / control
    logic                       wr_real_en;
    logic                       wr_imag_en;
    logic [LIMB_INDEX_BITS-1:0] wr_ind;
    logic [DATA_BITS-1:0]       limb_data;
    logic                       wr_num_limbs_en;
    logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
    logic                       wr_iter_lim_en;
    logic [15:0]                iter_lim_data;
    logic                       start;
    logic                       out_ready;
    logic [15:0]                iteration_count;
    // Result stream
    logic                       res_valid;
    logic                       res_ready;
    logic [TAG_BITS-1:0]        res_tag;
    logic [15:0]                res_count;
    logic                       res_escaped;
    logic                       res_err;
    logic                       busy;

    // Dispatcher side
    modport master (
        input  in_valid, in_data, out_ready, iteration_count, res_ready,
        output in_ready, wr_real_en, wr_imag_en, wr_ind, limb_data, wr_num_limbs_en,
               num_limbs_data, wr_iter_lim_en, iter_lim_data, start, res_valid, res_tag,
               res_count, res_escaped, res_err, busy
    );

    // Host / solver / consumer side
    modport slave (
        output in_valid, in_data, out_ready, iteration_count, res_ready,
        input  in_ready, wr_real_en, wr_imag_en, wr_ind, limb_data, wr_num_limbs_en,
               num_limbs_data, wr_iter_lim_en, iter_lim_data, start, res_valid, res_tag,
               res_count, res_escaped, res_err, busy
    );
endinterface

// File: rtl/solver_dispatch.sv
// Feeds pixel jobs (header, real limbs, imag limbs) into the solver, starts it, waits for
// completion and returns the tagged iteration count through a one-entry result register.
module solver_dispatch #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int DATA_BITS       = 32,
    parameter int TAG_BITS        = 8
) (
    input logic                clock,
    input logic                reset_n,
    solver_dispatch_if.master  bus
);

    typedef enum logic [2:0] {
        S_HDR, S_RE, S_IM, S_START, S_WLOW, S_WDONE, S_ERR
    } state_t;

    state_t                     r_state;
    logic [LIMB_INDEX_BITS-1:0] r_cnt;
    logic [TAG_BITS-1:0]        r_tag;

    logic                       r_wr_real_en;
    logic                       r_wr_imag_en;
    logic [LIMB_INDEX_BITS-1:0] r_wr_ind;
    logic [DATA_BITS-1:0]       r_limb_data;
    logic                       r_wr_num_limbs_en;
    logic [LIMB_INDEX_BITS-1:0] r_num_limbs_data;
    logic                       r_wr_iter_lim_en;
    logic [15:0]                r_iter_lim_data;
    logic                       r_start;
    logic                       r_res_valid;
    logic [TAG_BITS-1:0]        r_res_tag;
    logic [15:0]                r_res_count;
    logic                       r_res_escaped;
    logic                       r_res_err;

    logic                       w_in_ready;
    logic                       w_hs;
    logic                       w_last;
    logic [LIMB_INDEX_BITS-1:0] w_hdr_num_limbs;

    // Host words are only taken while loading a job
    assign w_in_ready      = (r_state == S_HDR) || (r_state == S_RE) || (r_state == S_IM);
    assign w_hs            = bus.in_valid && w_in_ready;
    assign w_hdr_num_limbs = bus.in_data[16 +: LIMB_INDEX_BITS];
    // num_limbs_data keeps the job's limb count after its load pulse
    assign w_last          = (r_cnt == r_num_limbs_data - LIMB_INDEX_BITS'(1));

    // Job sequencer with registered solver-side and result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_HDR;
            r_cnt             <= '0;
            r_tag             <= '0;
            r_wr_real_en      <= 1'b0;
            r_wr_imag_en      <= 1'b0;
            r_wr_ind          <= '0;
            r_limb_data       <= '0;
            r_wr_num_limbs_en <= 1'b0;
            r_num_limbs_data  <= '0;
            r_wr_iter_lim_en  <= 1'b0;
            r_iter_lim_data   <= '0;
            r_start           <= 1'b0;
            r_res_valid       <= 1'b0;
            r_res_tag         <= '0;
            r_res_count       <= '0;
            r_res_escaped     <= 1'b0;
            r_res_err         <= 1'b0;
        end else begin
            r_wr_real_en      <= 1'b0;
            r_wr_imag_en      <= 1'b0;
            r_wr_num_limbs_en <= 1'b0;
            r_wr_iter_lim_en  <= 1'b0;
            r_start           <= 1'b0;

            // Consumer clear; a capture below in the same cycle overrides it
            if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end

            case (r_state)
                S_HDR: begin
                    if (w_hs) begin
                        r_tag <= bus.in_data[DATA_BITS-1 -: TAG_BITS];
                        if (w_hdr_num_limbs == '0) begin
                            r_state <= S_ERR;
                        end else begin
                            r_wr_num_limbs_en <= 1'b1;
                            r_wr_iter_lim_en  <= 1'b1;
                            r_num_limbs_data  <= w_hdr_num_limbs;
                            r_iter_lim_data   <= bus.in_data[15:0];
                            r_cnt             <= '0;
                            r_state           <= S_RE;
                        end
                    end
                end
                S_RE, S_IM: begin
                    if (w_hs) begin
                        r_wr_real_en <= (r_state == S_RE);
                        r_wr_imag_en <= (r_state == S_IM);
                        r_wr_ind     <= r_cnt;
                        r_limb_data  <= bus.in_data;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= (r_state == S_RE) ? S_IM : S_START;
                        end else begin
                            r_cnt <= r_cnt + LIMB_INDEX_BITS'(1);
                        end
                    end
                end
                S_START: begin
                    r_start <= 1'b1;
                    r_state <= S_WLOW;
                end
                S_WLOW: begin
                    // A high out_ready here may be left over from the previous job
                    if (!bus.out_ready) begin
                        r_state <= S_WDONE;
                    end
                end
                S_WDONE: begin
                    if (bus.out_ready && !r_res_valid) begin
                        r_res_valid   <= 1'b1;
                        r_res_tag     <= r_tag;
                        r_res_count   <= bus.iteration_count;
                        r_res_escaped <= (bus.iteration_count != 16'hFFFF);
                        r_res_err     <= 1'b0;
                        r_state       <= S_HDR;
                    end
                end
                S_ERR: begin
                    if (!r_res_valid) begin
                        r_res_valid   <= 1'b1;
                        r_res_tag     <= r_tag;
                        r_res_count   <= '0;
                        r_res_escaped <= 1'b0;
                        r_res_err     <= 1'b1;
                        r_state       <= S_HDR;
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.wr_real_en      = r_wr_real_en;
    assign bus.wr_imag_en      = r_wr_imag_en;
    assign bus.wr_ind          = r_wr_ind;
    assign bus.limb_data       = r_limb_data;
    assign bus.wr_num_limbs_en = r_wr_num_limbs_en;
    assign bus.num_limbs_data  = r_num_limbs_data;
    assign bus.wr_iter_lim_en  = r_wr_iter_lim_en;
    assign bus.iter_lim_data   = r_iter_lim_data;
    assign bus.start           = r_start;
    assign bus.res_valid       = r_res_valid;
    assign bus.res_tag         = r_res_tag;
    assign bus.res_count       = r_res_count;
    assign bus.res_escaped     = r_res_escaped;
    assign bus.res_err         = r_res_err;
    assign bus.busy            = (r_state != S_HDR);

endmodule

// File: tb/tb_solver_dispatch.sv
// Scoreboard bench for solver_dispatch: directed jobs push expected solver writes and results,
// independent monitors pop and compare what the DUT presents.
module tb_solver_dispatch;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    solver_dispatch_if bus ();

    solver_dispatch dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          kind;  // 0 num/iter load, 1 real, 2 imag, 3 start
        int          idx;
        logic [31:0] data;
    } wexp_t;

    typedef struct {
        logic [7:0]  tag;
        logic [15:0] count;
        logic        esc;
        logic        err;
    } rexp_t;

    wexp_t       wq[$];
    rexp_t       rq[$];
    logic [15:0] cq[$];

    int checks = 0;
    int errors = 0;

    // Solver model: drops out_ready the cycle after start, finishes 4 cycles later
    int          sol_lat;
    logic [15:0] sol_pend;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_ready       <= 1'b1;
            bus.iteration_count <= 16'h0;
            sol_lat             <= 0;
            sol_pend            <= 16'h0;
        end else if (bus.start) begin
            bus.out_ready <= 1'b0;
            sol_lat       <= 4;
            if (cq.size() > 0) sol_pend <= cq.pop_front();
        end else if (sol_lat > 1) begin
            sol_lat <= sol_lat - 1;
        end else if (sol_lat == 1) begin
            sol_lat             <= 0;
            bus.out_ready       <= 1'b1;
            bus.iteration_count <= sol_pend;
        end
    end

    task automatic chk_w(input int k, input int idx, input logic [31:0] d);
        wexp_t e;
        checks++;
        if (wq.size() == 0) begin
            errors++;
            $display("FAIL solver_write: got kind=%0d idx=%0d data=%h, required none", k, idx, d);
        end else begin
            e = wq.pop_front();
            if (e.kind != k || e.idx != idx || e.data !== d) begin
                errors++;
                $display("FAIL solver_write: got kind=%0d idx=%0d data=%h, required kind=%0d idx=%0d data=%h",
                         k, idx, d, e.kind, e.idx, e.data);
            end
        end
    endtask

    // Solver-side monitor; kind 4 = partial load pulse, 5 = start overlapping a limb write
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.wr_num_limbs_en || bus.wr_iter_lim_en)
                chk_w((bus.wr_num_limbs_en && bus.wr_iter_lim_en) ? 0 : 4,
                      int'(bus.num_limbs_data), {16'h0, bus.iter_lim_data});
            if (bus.wr_real_en) chk_w(1, int'(bus.wr_ind), bus.limb_data);
            if (bus.wr_imag_en) chk_w(2, int'(bus.wr_ind), bus.limb_data);
            if (bus.start) chk_w((bus.wr_real_en || bus.wr_imag_en) ? 5 : 3, 0, 32'h0);
        end
    end

    // Result monitor
    always @(negedge clock) begin
        rexp_t e;
        if (reset_n && bus.res_valid && bus.res_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL result: got tag=%h count=%h esc=%b err=%b, required none",
                         bus.res_tag, bus.res_count, bus.res_escaped, bus.res_err);
            end else begin
                e = rq.pop_front();
                if ({bus.res_tag, bus.res_count, bus.res_escaped, bus.res_err} !==
                    {e.tag, e.count, e.esc, e.err}) begin
                    errors++;
                    $display("FAIL result: got tag=%h count=%h esc=%b err=%b, required tag=%h count=%h esc=%b err=%b",
                             bus.res_tag, bus.res_count, bus.res_escaped, bus.res_err,
                             e.tag, e.count, e.esc, e.err);
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({bus.wr_real_en, bus.wr_imag_en, bus.wr_ind, bus.limb_data,
                     bus.wr_num_limbs_en, bus.num_limbs_data, bus.wr_iter_lim_en,
                     bus.iter_lim_data, bus.start, bus.res_valid, bus.res_tag, bus.res_count,
                     bus.res_escaped, bus.res_err, bus.busy});
    endfunction

    task automatic send(input logic [31:0] w, input bit bub);
        bit ok;
        if (bub) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clock);
            ok = bus.in_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 1000 cycles, required 1");
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Stream one job; abort_im >= 0 stops after that many imag limbs (no result expected)
    task automatic job(input logic [7:0] tag, input int nl, input logic [15:0] iter,
                       input logic [31:0] re0, input logic [31:0] im0, input logic [15:0] cnt,
                       input bit bub, input int abort_im);
        rexp_t r;
        logic [5:0] nl6;
        nl6 = 6'(nl);
        if (nl == 0) r = '{tag: tag, count: 16'h0, esc: 1'b0, err: 1'b1};
        else         r = '{tag: tag, count: cnt, esc: (cnt != 16'hFFFF), err: 1'b0};
        if (abort_im < 0) rq.push_back(r);
        if (nl != 0) begin
            wq.push_back('{kind: 0, idx: nl, data: {16'h0, iter}});
            for (int i = 0; i < nl; i++) wq.push_back('{kind: 1, idx: i, data: re0 + 32'(i)});
            for (int i = 0; i < nl; i++) wq.push_back('{kind: 2, idx: i, data: im0 + 32'(i)});
            if (abort_im < 0) begin
                wq.push_back('{kind: 3, idx: 0, data: 32'h0});
                cq.push_back(cnt);
            end
        end
        // Bits 23:22 are set to show they are ignored
        send({tag, 2'b11, nl6, iter}, bub);
        for (int i = 0; i < nl; i++) send(re0 + 32'(i), bub);
        for (int i = 0; i < nl; i++) begin
            if (abort_im >= 0 && i == abort_im) break;
            send(im0 + 32'(i), bub);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clock);
            done = (rq.size() == 0) && (wq.size() == 0) && !bus.busy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got rq=%0d wq=%0d busy=%b, required 0 0 0",
                     rq.size(), wq.size(), bus.busy);
        end
        @(posedge clock);
        #1;
    endtask

    logic [25:0] snap;
    bit          stable;
    bit          seen;
    int          acc;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.res_ready = 1'b1;
        reset_n       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        cmp("reset_outputs", out_vec(), 128'h0);
        cmp("reset_in_ready", 128'(bus.in_ready), 128'h1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic job
        job(8'h5A, 2, 16'd100, 32'h1, 32'h3, 16'd37, 1'b0, -1);
        drain();
        // Limit reached; out_ready is stale high (count 37) when start fires
        job(8'h21, 3, 16'd500, 32'h10, 32'h20, 16'hFFFF, 1'b0, -1);
        drain();
        // Zero limbs -> error result, solver untouched
        job(8'h11, 0, 16'd9, 32'h0, 32'h0, 16'h0, 1'b0, -1);
        drain();

        // Consumer stalls 50 cycles while a second job is solved
        bus.res_ready = 1'b0;
        job(8'h33, 1, 16'd7, 32'hA, 32'hB, 16'd12, 1'b0, -1);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            seen = bus.res_valid;
        end
        cmp("hold_first_valid", 128'(seen), 128'h1);
        snap   = {bus.res_tag, bus.res_count, bus.res_escaped, bus.res_err};
        stable = 1'b1;
        fork
            job(8'h44, 2, 16'd9, 32'h55, 32'h66, 16'd200, 1'b1, -1);
            begin
                repeat (50) begin
                    @(negedge clock);
                    if ({bus.res_valid, bus.res_tag, bus.res_count, bus.res_escaped, bus.res_err}
                        !== {1'b1, snap}) stable = 1'b0;
                end
            end
        join
        cmp("hold_stable", 128'(stable), 128'h1);
        cmp("hold_second_waiting", 128'(bus.busy), 128'h1);
        cmp("hold_tag", 128'(bus.res_tag), 128'h33);
        @(posedge clock);
        #1;
        bus.res_ready = 1'b1;
        drain();

        // Largest limb count, index wraps cleanly
        job(8'h63, 63, 16'hFFFE, 32'h1000, 32'h2000, 16'hFFFE, 1'b0, -1);
        drain();

        // Reset in the middle of the imag limbs with in_valid toggling
        job(8'h77, 4, 16'd50, 32'h100, 32'h200, 16'd99, 1'b1, 1);
        acc = 1;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 32'h200 + 32'(acc);
            @(posedge clock);
            if (bus.in_valid) acc++;
            if (k == 0) #1;
        end
        #1;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        cmp("midjob_reset_outputs", out_vec(), 128'h0);
        cmp("midjob_reset_in_ready", 128'(bus.in_ready), 128'h1);
        wq.delete();
        cq.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        job(8'h78, 2, 16'd60, 32'h300, 32'h400, 16'd5, 1'b1, -1);
        drain();

        cmp("final_wq_empty", 128'(wq.size()), 128'h0);
        cmp("final_rq_empty", 128'(rq.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
